// File: rtl/fpga_apb_requester.sv
// fpga_apb_requester: single-outstanding APB3/APB4 initiator for the Caliptra
// APB slave port. The host posts one request on a valid/ready channel; the
// block runs SETUP then ACCESS (with wait states) and returns read data and
// error status on a valid/ready response channel.
// Optional build macro FPGA_APB_TIMEOUT_EN adds an ACCESS-phase wait limit of
// TIMEOUT_CYCLES cycles; without it rsp_timeout is tied low and ACCESS waits
// indefinitely for PREADY.
module fpga_apb_requester #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int USER_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              core_clk,
  input  logic              core_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [USER_W-1:0] req_pauser,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  output logic [2:0]        PPROT,
  output logic [USER_W-1:0] PAUSER,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;

`ifdef FPGA_APB_TIMEOUT_EN
  // Count value at which the next PREADY=0 ACCESS cycle reaches the limit.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;
`else
  assign rsp_timeout = 1'b0;
`endif

  // Decoded directly from state so the host sees acceptance in the same cycle.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign PPROT     = 3'b000;

  // Transfer FSM with registered APB and response outputs.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state     <= IDLE;
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      PAUSER    <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef FPGA_APB_TIMEOUT_EN
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            PADDR  <= req_addr;
            PWDATA <= req_wdata;
            PWRITE <= req_write;
            PAUSER <= req_pauser;
            PSEL   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
`ifdef FPGA_APB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          // PREADY has priority over a timeout reached in the same cycle.
          if (PREADY) begin
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
`ifdef FPGA_APB_TIMEOUT_EN
            rsp_timeout <= 1'b0;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_apb_requester.sv
// Directed plus randomized bench for fpga_apb_requester. The reference model
// predicts response latency, data and status from the transfer parameters
// (wait count, slave error, direction) rather than from the FSM.
module tb_fpga_apb_requester;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int UW = 32;
  localparam int TO = 16;

  logic          core_clk = 1'b0;
  logic          core_rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [UW-1:0] req_pauser;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          busy;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [2:0]    PPROT;
  logic [UW-1:0] PAUSER;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int n_cmp = 0;
  int n_bad = 0;

  fpga_apb_requester #(
    .ADDR_W(AW), .DATA_W(DW), .USER_W(UW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pauser(req_pauser),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PPROT(PPROT), .PAUSER(PAUSER),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 core_clk = ~core_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transfer: drive request, act as APB slave inserting `waits`
  // PREADY=0 cycles, check against the model, then hold the response `hold`
  // cycles (optionally with a new request pending) before the handshake.
  task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [UW-1:0] user, input int waits, input logic [DW-1:0] prdata,
                      input bit slverr, input int hold, input bit pend);
    bit            to_en;
    int            n;
    int            exp_lat;
    bit            exp_to;
    bit            exp_err;
    logic [DW-1:0] exp_rd;
`ifdef FPGA_APB_TIMEOUT_EN
    to_en = 1'b1;
`else
    to_en = 1'b0;
`endif
    if (to_en && waits >= TO) begin
      exp_lat = 1 + TO; exp_to = 1'b1; exp_err = 1'b1; exp_rd = '0;
    end else begin
      exp_lat = 2 + waits; exp_to = 1'b0; exp_err = slverr; exp_rd = wr ? '0 : prdata;
    end

    @(negedge core_clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_pauser = user;
    check("req_ready_idle", 128'(req_ready), 128'(1));
    @(posedge core_clk); #1;
    req_valid = 1'b0;
    req_addr = 32'($urandom); req_wdata = 32'($urandom); req_write = 1'($urandom);
    n = 0;
    while (!rsp_valid && n <= 100) begin
      check("apb_phase", 128'({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PAUSER}),
            128'({1'b1, (n >= 1), wr, addr, wdata, user}));
      if (n == 0) begin
        PREADY = 1'($urandom); PRDATA = 32'($urandom); PSLVERR = 1'($urandom);
      end else if (n - 1 >= waits) begin
        PREADY = 1'b1; PRDATA = prdata; PSLVERR = slverr;
      end else begin
        PREADY = 1'b0; PRDATA = 32'($urandom); PSLVERR = 1'($urandom);
      end
      @(posedge core_clk); #1;
      n++;
    end
    check("rsp_latency", 128'(n), 128'(exp_lat));
    check("rsp_fields", 128'({rsp_valid, rsp_rdata, rsp_err, rsp_timeout}),
          128'({1'b1, exp_rd, exp_err, exp_to}));
    check("resp_ctrl", 128'({PSEL, PENABLE, busy, req_ready, PPROT}), 128'({4'b0010, 3'b000}));

    for (int h = 0; h < hold; h++) begin
      if (pend) req_valid = 1'b1;
      PREADY = 1'($urandom); PRDATA = 32'($urandom); PSLVERR = 1'($urandom);
      @(posedge core_clk); #1;
      check("resp_hold", 128'({rsp_valid, PSEL, PENABLE, req_ready, rsp_rdata, rsp_err}),
            128'({4'b1000, exp_rd, exp_err}));
    end
    rsp_ready = 1'b1;
    @(posedge core_clk); #1;
    rsp_ready = 1'b0;
    check("after_handshake", 128'({rsp_valid, req_ready, busy, PSEL, PADDR, PWRITE}),
          128'({4'b0100, addr, wr}));
  endtask

  initial begin
    core_rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_pauser = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    #1;
    check("reset_ctrl", 128'({PSEL, PENABLE, rsp_valid, rsp_err, rsp_timeout, busy, req_ready}),
          128'(7'b0000001));
    check("reset_data", 128'({PADDR, PWDATA, PWRITE, PAUSER, rsp_rdata, PPROT}), 128'(0));
    repeat (2) @(negedge core_clk);
    core_rst = 1'b0;

    // Zero-wait read.
    xfer(1'b0, 32'h3002_0000, 32'h0, 32'h1, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    // Write with three wait states.
    xfer(1'b1, 32'h3002_0010, 32'h1234_5678, 32'hCAFE, 3, 32'hFFFF_FFFF, 1'b0, 1, 1'b0);
    // Read returning a slave error.
    xfer(1'b0, 32'h3002_0020, 32'h0, 32'h7, 2, 32'hA5A5_5A5A, 1'b1, 0, 1'b0);
    // Response back-pressure with the next request already pending.
    xfer(1'b0, 32'h3002_0030, 32'h0, 32'h2, 1, 32'h0BAD_F00D, 1'b0, 10, 1'b1);
    xfer(1'b1, 32'h3002_0040, 32'h7777_0001, 32'h3, 0, 32'h1111_2222, 1'b1, 0, 1'b0);
`ifdef FPGA_APB_TIMEOUT_EN
    // Slave never ready, then ready exactly on the last allowed cycle.
    xfer(1'b0, 32'h3002_0050, 32'h0, 32'h4, 1000, 32'h5555_5555, 1'b0, 0, 1'b0);
    xfer(1'b0, 32'h3002_0060, 32'h0, 32'h5, TO - 1, 32'h6666_6666, 1'b0, 0, 1'b0);
`endif

    // Reset in the middle of ACCESS.
    @(negedge core_clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h3002_0070; req_pauser = 32'h9;
    @(posedge core_clk); #1;
    req_valid = 1'b0; PREADY = 1'b0;
    repeat (3) @(posedge core_clk);
    #2 core_rst = 1'b1;
    #1 check("async_reset", 128'({PSEL, PENABLE, rsp_valid, busy, req_ready}), 128'(5'b00001));
    @(negedge core_clk);
    core_rst = 1'b0;
    @(posedge core_clk); #1;
    check("post_reset_idle", 128'({req_ready, PSEL, rsp_valid}), 128'(3'b100));
    xfer(1'b0, 32'h3002_0080, 32'h0, 32'hA, 1, 32'h1357_9BDF, 1'b0, 0, 1'b0);

    // Randomized transfers.
    for (int i = 0; i < 12; i++) begin
      xfer(1'($urandom), 32'($urandom), 32'($urandom), 32'($urandom),
           int'($urandom_range(0, 5)), 32'($urandom), 1'($urandom),
           int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
